cycle_sequencer: RTL and testbench
==================================

Name: cycle_sequencer

Overview:
- Timing source that drives the per-instruction microcode blocks.
- Generates the one-hot T-step (4 per M-cycle) and one-hot M-cycle count that the microcode decodes.
- Consumes the microcode's OR-reduced IR-fetch request and runs the overlapped opcode fetch: PC onto the address bus, bus data latched into the IR, PC incremented.
- Handles the 0xCB prefix, the stall input, and M-cycle counter overrun.

Parameters:
- STEPS, 4, T-steps per M-cycle; width of o_Cycle_Step.
- CYCLES, 8, maximum M-cycles per instruction; width of o_Cycle_Count.
- RESET_OPCODE, 8'h00, IR value after reset (NOP).

Ports:
- i_Clk  input  1  system clock, rising edge
- i_Reset_n  input  1  synchronous active-low reset
- i_Stall  input  1  freeze all state, for bus wait or debug
- i_IR_Fetch  input  1  OR of every microcode o_IR_Fetch; marks the current M-cycle as the fetch cycle
- i_Data  input  8  data bus into the core
- o_Cycle_Step  output  STEPS  one-hot T-step
- o_Cycle_Count  output  CYCLES  one-hot M-cycle within the instruction
- o_IR  output  8  current opcode
- o_CB_Prefix  output  1  o_IR is a CB-table opcode
- o_Fetch_Address_Out  output  1  drive PC onto the address bus
- o_Fetch_PC_Increment  output  1  PC += 1
- o_Fetch_Bus_In  output  1  enable data bus into the core
- o_Instr_Start  output  1  one-clock pulse: new opcode is valid in o_IR
- o_Overrun  output  1  sticky: count ran past bit CYCLES-1 without a fetch

Behaviour:
- Synchronous reset, when i_Reset_n=0 at a clock edge:
  - o_Cycle_Step=0001, o_Cycle_Count=00000001, o_IR=RESET_OPCODE
  - o_CB_Prefix=0, o_Overrun=0, o_Instr_Start=0
  - boot_fetch=1 (internal flag)
  - Reset dominates i_Stall. Reset mid-fetch discards the partial opcode.
- Fetch-cycle flag: fetch_cyc = (i_IR_Fetch | boot_fetch).
  - Sampled every clock (not latched). Microcode holds it stable for the whole M-cycle.
- Step ring, when not stalled: rotate left each clock, 0001→0010→0100→1000→0001.
- Fetch strobes (combinational, all gated by fetch_cyc and not stalled):
  - o_Fetch_Address_Out = Step[1]
  - o_Fetch_PC_Increment = Step[1]
  - o_Fetch_Bus_In = Step[2]
- Edge at end of Step[2] with fetch_cyc:
  - i_Data is captured into a staging register, op_next.
  - o_IR does not change here, so microcode keeps decoding the old opcode through Step[3].
- Edge at end of Step[3] (M-cycle boundary):
  - With fetch_cyc:
    - o_Cycle_Count←00000001.
    - If op_next==8'hCB and o_CB_Prefix==0: o_CB_Prefix←1, o_IR←8'hCB, boot_fetch←1 so the next M-cycle fetches the real opcode, o_Instr_Start←0.
    - Otherwise: o_IR←op_next, o_CB_Prefix←(o_IR==8'hCB && o_CB_Prefix), boot_fetch←0, o_Instr_Start←1 for exactly one clock.
  - Without fetch_cyc:
    - o_Cycle_Count shifts left one position.
    - If bit CYCLES-1 was set: wrap to 00000001, set o_Overrun (cleared only by reset), force boot_fetch←1 for recovery.
- Latency:
  - Opcode on i_Data at the Step[2] edge appears on o_IR 1 clock later, at the start of the new Step[0].
  - Prefixed instruction: CB then opcode, 8 clocks from first fetch to o_Instr_Start.
- i_Stall=1:
  - Step, count, IR, staging and flags all hold.
  - o_Instr_Start is forced 0.
  - All fetch strobes are forced 0.
- Simultaneous events:
  - Fetch at count bit CYCLES-1 is legal: no overrun.
  - i_IR_Fetch asserted on a Step[3] boundary while stalled has no effect until the stall is released.
- Operand widths:
  - Step and count are always exactly one-hot after reset.
  - A non-one-hot state is a design error; flag it with an assertion only.

Decomposition:
- Shared control package:
  - STEP_* one-hot constants (STEP_0..STEP_3)
  - M-cycle constants (MC_0..MC_7)
  - OPC_CB_PREFIX = 8'hCB and OPC_NOP = 8'h00
- The microcode blocks consume the same package.
- One natural sub-module: onehot_ring, parameterised width, with enable, load-first and shift/rotate mode. Instantiate it twice, once for step (rotate) and once for count (shift-with-reload).
- IR/prefix logic stays in the top.

Test Plan:
- Reset then release, i_Data=8'h18 at Step[2], i_IR_Fetch=0 → boot fetch:
  - o_Fetch_Address_Out high at clock 2
  - o_IR=8'h18 and o_Instr_Start=1 at clock 4
  - o_Cycle_Count=00000001
- Model JR taken: i_IR_Fetch=1 only while count bit2, next opcode 8'h00 → count goes 001→010→100→001 across 12 clocks, o_IR=8'h00, one o_Instr_Start pulse.
- Prefix: fetch 8'hCB then 8'h7C → o_CB_Prefix=1 and o_IR=8'h7C after 8 clocks, single o_Instr_Start. The next fetch of 8'h00 clears o_CB_Prefix.
- i_Stall=1 for 5 clocks at Step[1] of a fetch cycle → step/count frozen, strobes 0, PC increment asserted exactly once overall.
- Never assert i_IR_Fetch after the first instruction → o_Overrun=1 after 8 M-cycles (32 clocks), count=00000001, recovery fetch occurs.
- Reset asserted at Step[2] of a fetch with i_Data=8'hCB → o_IR=8'h00, o_CB_Prefix=0, step=0001 on the next clock.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared timing constants for the cycle sequencer and the microcode blocks that decode its T-step/M-cycle outputs.
package cycle_sequencer_pkg;

   localparam int unsigned STEPS_DEF  = 4;
   localparam int unsigned CYCLES_DEF = 8;
   localparam int unsigned OPC_W      = 8;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam logic [STEPS_DEF-1:0] STEP_0 = 4'b0001;
   localparam logic [STEPS_DEF-1:0] STEP_1 = 4'b0010;
   localparam logic [STEPS_DEF-1:0] STEP_2 = 4'b0100;
   localparam logic [STEPS_DEF-1:0] STEP_3 = 4'b1000;

   localparam logic [CYCLES_DEF-1:0] MC_0 = 8'b0000_0001;
   localparam logic [CYCLES_DEF-1:0] MC_1 = 8'b0000_0010;
   localparam logic [CYCLES_DEF-1:0] MC_2 = 8'b0000_0100;
   localparam logic [CYCLES_DEF-1:0] MC_3 = 8'b0000_1000;
   localparam logic [CYCLES_DEF-1:0] MC_4 = 8'b0001_0000;
   localparam logic [CYCLES_DEF-1:0] MC_5 = 8'b0010_0000;
   localparam logic [CYCLES_DEF-1:0] MC_6 = 8'b0100_0000;
   localparam logic [CYCLES_DEF-1:0] MC_7 = 8'b1000_0000;

   localparam opcode_t OPC_CB_PREFIX = 8'hCB;
   localparam opcode_t OPC_NOP       = 8'h00;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Sequencer <-> microcode/bus signal bundle; master is the sequencer side.
interface cycle_sequencer_if
   import cycle_sequencer_pkg::*;
#(
   parameter int unsigned STEPS  = STEPS_DEF,
   parameter int unsigned CYCLES = CYCLES_DEF
);
   logic              i_Stall;
   logic              i_IR_Fetch;
   opcode_t           i_Data;
   logic [STEPS-1:0]  o_Cycle_Step;
   logic [CYCLES-1:0] o_Cycle_Count;
   opcode_t           o_IR;
   logic              o_CB_Prefix;
   logic              o_Fetch_Address_Out;
   logic              o_Fetch_PC_Increment;
   logic              o_Fetch_Bus_In;
   logic              o_Instr_Start;
   logic              o_Overrun;

   modport master (
      input  i_Stall, i_IR_Fetch, i_Data,
      output o_Cycle_Step, o_Cycle_Count, o_IR, o_CB_Prefix,
             o_Fetch_Address_Out, o_Fetch_PC_Increment, o_Fetch_Bus_In,
             o_Instr_Start, o_Overrun
   );

   modport slave (
      output i_Stall, i_IR_Fetch, i_Data,
      input  o_Cycle_Step, o_Cycle_Count, o_IR, o_CB_Prefix,
             o_Fetch_Address_Out, o_Fetch_PC_Increment, o_Fetch_Bus_In,
             o_Instr_Start, o_Overrun
   );
endinterface

// File: rtl/cycle_sequencer_onehot_ring.sv
// One-hot ring register: reset/load to bit 0, then rotate (ROTATE=1) or shift left (ROTATE=0) when enabled.
module cycle_sequencer_onehot_ring #(
   parameter int unsigned WIDTH  = 4,
   parameter bit          ROTATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   output logic [WIDTH-1:0] ring_o
);
   logic [WIDTH-1:0] ring_q;
   logic [WIDTH-1:0] ring_d;

   always_comb begin
      ring_d = ring_q;
      if (en) begin
         if (load)        ring_d = WIDTH'(1);
         else if (ROTATE) ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
         else             ring_d = {ring_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ring_q <= WIDTH'(1);
      else        ring_q <= ring_d;
   end

   assign ring_o = ring_q;
endmodule

// File: rtl/cycle_sequencer.sv
// Instruction timing source: T-step/M-cycle rings, overlapped opcode fetch, CB prefix and overrun recovery.
module cycle_sequencer
   import cycle_sequencer_pkg::*;
#(
   parameter int unsigned STEPS        = STEPS_DEF,
   parameter int unsigned CYCLES       = CYCLES_DEF,
   parameter opcode_t     RESET_OPCODE = OPC_NOP
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   cycle_sequencer_if.master bus
);
   logic [STEPS-1:0]  step;
   logic [CYCLES-1:0] count;
   logic              run;
   logic              fetch_cyc;
   logic              mc_end;
   logic              count_load;

   opcode_t ir_q, ir_d;
   opcode_t op_next_q, op_next_d;
   logic    cb_q, cb_d;
   logic    boot_q, boot_d;
   logic    start_q, start_d;
   logic    overrun_q, overrun_d;

   assign run        = ~bus.i_Stall;
   assign fetch_cyc  = bus.i_IR_Fetch | boot_q;
   assign mc_end     = run & step[3];
   // A fetch, or running off the top of the count, both restart at M-cycle 0.
   assign count_load = fetch_cyc | count[CYCLES-1];

   cycle_sequencer_onehot_ring #(.WIDTH(STEPS), .ROTATE(1'b1)) u_step_ring (
      .clk    (i_Clk),
      .rst_n  (i_Reset_n),
      .en     (run),
      .load   (1'b0),
      .ring_o (step)
   );

   cycle_sequencer_onehot_ring #(.WIDTH(CYCLES), .ROTATE(1'b0)) u_count_ring (
      .clk    (i_Clk),
      .rst_n  (i_Reset_n),
      .en     (mc_end),
      .load   (count_load),
      .ring_o (count)
   );

   always_comb begin
      ir_d      = ir_q;
      op_next_d = op_next_q;
      cb_d      = cb_q;
      boot_d    = boot_q;
      start_d   = 1'b0;
      overrun_d = overrun_q;

      // Stage the opcode so microcode keeps decoding the old IR through Step[3].
      if (run && fetch_cyc && step[2]) op_next_d = bus.i_Data;

      if (mc_end) begin
         if (fetch_cyc) begin
            if ((op_next_q == OPC_CB_PREFIX) && !cb_q) begin
               ir_d   = OPC_CB_PREFIX;
               cb_d   = 1'b1;
               boot_d = 1'b1;
            end else begin
               ir_d    = op_next_q;
               cb_d    = (ir_q == OPC_CB_PREFIX) && cb_q;
               boot_d  = 1'b0;
               start_d = 1'b1;
            end
         end else if (count[CYCLES-1]) begin
            overrun_d = 1'b1;
            boot_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         ir_q      <= RESET_OPCODE;
         op_next_q <= RESET_OPCODE;
         cb_q      <= 1'b0;
         boot_q    <= 1'b1;
         start_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ir_q      <= ir_d;
         op_next_q <= op_next_d;
         cb_q      <= cb_d;
         boot_q    <= boot_d;
         start_q   <= start_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.o_Cycle_Step         = step;
   assign bus.o_Cycle_Count        = count;
   assign bus.o_IR                 = ir_q;
   assign bus.o_CB_Prefix          = cb_q;
   assign bus.o_Overrun            = overrun_q;
   assign bus.o_Instr_Start        = start_q & run;
   assign bus.o_Fetch_Address_Out  = run & fetch_cyc & step[1];
   assign bus.o_Fetch_PC_Increment = run & fetch_cyc & step[1];
   assign bus.o_Fetch_Bus_In       = run & fetch_cyc & step[2];

   onehot_state_a : assert property (@(posedge i_Clk) disable iff (!i_Reset_n)
      ($onehot(step) && $onehot(count)));
endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: boot fetch, JR-style fetch, CB prefix, stall, overrun and mid-fetch reset.
module tb_cycle_sequencer;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   pc_inc_cnt;

   cycle_sequencer_if bus ();

   cycle_sequencer dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count clock edges at which the PC-increment strobe is active.
   always @(posedge clk) if (bus.o_Fetch_PC_Increment === 1'b1) pc_inc_cnt <= pc_inc_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0; failures = 0; pc_inc_cnt = 0;
      rst_n = 1'b0;
      bus.i_Stall = 1'b0; bus.i_IR_Fetch = 1'b0; bus.i_Data = 8'h00;
      tick(3);
      check("rst_step",    32'(bus.o_Cycle_Step),  32'h1);
      check("rst_count",   32'(bus.o_Cycle_Count), 32'h01);
      check("rst_ir",      32'(bus.o_IR),          32'h00);
      check("rst_cb",      32'(bus.o_CB_Prefix),   32'h0);
      check("rst_overrun", 32'(bus.o_Overrun),     32'h0);
      check("rst_start",   32'(bus.o_Instr_Start), 32'h0);

      // Boot fetch of 0x18
      rst_n = 1'b1;
      #1 check("boot_addr_s0", 32'(bus.o_Fetch_Address_Out), 32'h0);
      tick(1);
      check("boot_step1",   32'(bus.o_Cycle_Step),         32'h2);
      check("boot_addr_s1", 32'(bus.o_Fetch_Address_Out),  32'h1);
      check("boot_pcinc",   32'(bus.o_Fetch_PC_Increment), 32'h1);
      check("boot_busin1",  32'(bus.o_Fetch_Bus_In),       32'h0);
      bus.i_Data = 8'h18;
      tick(1);
      check("boot_busin2",  32'(bus.o_Fetch_Bus_In),       32'h1);
      tick(1);
      check("boot_ir_hold", 32'(bus.o_IR),                 32'h00);
      bus.i_Data = 8'hFF;
      tick(1);
      check("boot_ir",      32'(bus.o_IR),                 32'h18);
      check("boot_start",   32'(bus.o_Instr_Start),        32'h1);
      check("boot_count",   32'(bus.o_Cycle_Count),        32'h01);
      check("boot_step0",   32'(bus.o_Cycle_Step),         32'h1);
      tick(1);
      check("boot_start_pulse", 32'(bus.o_Instr_Start),    32'h0);
      check("nofetch_addr",     32'(bus.o_Fetch_Address_Out), 32'h0);

      // JR-style: fetch only in M-cycle 2
      tick(3);
      check("jr_count1", 32'(bus.o_Cycle_Count), 32'h02);
      tick(4);
      check("jr_count2", 32'(bus.o_Cycle_Count), 32'h04);
      bus.i_IR_Fetch = 1'b1; bus.i_Data = 8'h00;
      tick(3);
      check("jr_start_early", 32'(bus.o_Instr_Start), 32'h0);
      tick(1);
      check("jr_count0", 32'(bus.o_Cycle_Count), 32'h01);
      check("jr_ir",     32'(bus.o_IR),          32'h00);
      check("jr_start",  32'(bus.o_Instr_Start), 32'h1);

      // CB prefix then 0x7C, then 0x00 clears the prefix
      bus.i_Data = 8'hCB;
      tick(4);
      check("cb_ir",     32'(bus.o_IR),          32'hCB);
      check("cb_flag",   32'(bus.o_CB_Prefix),   32'h1);
      check("cb_nostart",32'(bus.o_Instr_Start), 32'h0);
      bus.i_Data = 8'h7C;
      tick(4);
      check("cb_op_ir",   32'(bus.o_IR),          32'h7C);
      check("cb_op_flag", 32'(bus.o_CB_Prefix),   32'h1);
      check("cb_op_start",32'(bus.o_Instr_Start), 32'h1);
      bus.i_Data = 8'h00;
      tick(4);
      check("cb_clr_ir",   32'(bus.o_IR),        32'h00);
      check("cb_clr_flag", 32'(bus.o_CB_Prefix), 32'h0);

      // Stall for 5 clocks at Step[1] of a fetch cycle
      tick(1);
      pc_inc_cnt = 0;
      bus.i_Stall = 1'b1;
      #1;
      check("stall_addr",  32'(bus.o_Fetch_Address_Out),  32'h0);
      check("stall_pcinc", 32'(bus.o_Fetch_PC_Increment), 32'h0);
      tick(5);
      check("stall_step",  32'(bus.o_Cycle_Step),  32'h2);
      check("stall_count", 32'(bus.o_Cycle_Count), 32'h01);
      check("stall_pcinc2",32'(bus.o_Fetch_PC_Increment), 32'h0);
      bus.i_Stall = 1'b0; bus.i_Data = 8'hA5;
      tick(3);
      check("stall_ir",    32'(bus.o_IR),          32'hA5);
      check("stall_start", 32'(bus.o_Instr_Start), 32'h1);
      check("stall_pc_once", 32'(pc_inc_cnt),      32'd1);
      bus.i_Stall = 1'b1;
      #1 check("stall_start_gated", 32'(bus.o_Instr_Start), 32'h0);
      bus.i_Stall = 1'b0;

      // No further fetch requests: overrun after 8 M-cycles
      bus.i_IR_Fetch = 1'b0;
      tick(31);
      check("ovr_count7",  32'(bus.o_Cycle_Count), 32'h80);
      check("ovr_pre",     32'(bus.o_Overrun),     32'h0);
      tick(1);
      check("ovr_count0",  32'(bus.o_Cycle_Count), 32'h01);
      check("ovr_flag",    32'(bus.o_Overrun),     32'h1);
      tick(1);
      check("ovr_recover_addr", 32'(bus.o_Fetch_Address_Out), 32'h1);
      bus.i_Data = 8'h3C;
      tick(3);
      check("ovr_recover_ir",    32'(bus.o_IR),          32'h3C);
      check("ovr_recover_start", 32'(bus.o_Instr_Start), 32'h1);
      check("ovr_sticky",        32'(bus.o_Overrun),     32'h1);

      // Reset during Step[2] of a CB fetch discards it
      bus.i_IR_Fetch = 1'b1; bus.i_Data = 8'hCB;
      tick(2);
      check("mrst_step2", 32'(bus.o_Cycle_Step), 32'h4);
      rst_n = 1'b0;
      tick(1);
      check("mrst_ir",      32'(bus.o_IR),          32'h00);
      check("mrst_cb",      32'(bus.o_CB_Prefix),   32'h0);
      check("mrst_step",    32'(bus.o_Cycle_Step),  32'h1);
      check("mrst_overrun", 32'(bus.o_Overrun),     32'h0);
      rst_n = 1'b1; bus.i_IR_Fetch = 1'b0; bus.i_Data = 8'h00;
      tick(4);
      check("mrst_boot_ir",    32'(bus.o_IR),          32'h00);
      check("mrst_boot_start", 32'(bus.o_Instr_Start), 32'h1);
      check("mrst_boot_cb",    32'(bus.o_CB_Prefix),   32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
